// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory handshake
// and the instruction presented to the IF/ID register.
interface fetch_if;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Addr;
    logic [31:0] Inst;
    logic        InstValid;
    logic [31:0] PCF;

    modport master (
        input  StallF, PCSrcE, PCTargetE, imem_rvalid, imem_rdata,
        output imem_req, imem_addr, Addr, Inst, InstValid, PCF
    );

    modport slave (
        output StallF, PCSrcE, PCTargetE, imem_rvalid, imem_rdata,
        input  imem_req, imem_addr, Addr, Inst, InstValid, PCF
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32IM instruction-fetch stage: owns PCF, keeps one request outstanding to a
// variable-latency memory and squashes wrong-path responses after a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] addr_r;
    logic [31:0] inst_r;
    logic        valid_r;
    logic        req_s;

    function automatic logic [31:0] align_target(input logic [31:0] t);
        return t & 32'hFFFF_FFFC;
    endfunction

    // Request strobe: a new fetch leaves in ISSUE, or in HOLD the same cycle the
    // presented instruction is consumed; any redirect suppresses it.
    always_comb begin
        req_s = 1'b0;
        if (rst || bus.PCSrcE) begin
            req_s = 1'b0;
        end else begin
            case (state_r)
                ISSUE:   req_s = 1'b1;
                HOLD:    req_s = ~bus.StallF;
                default: req_s = 1'b0;
            endcase
        end
    end

    // Fetch FSM with PC, presented instruction and valid flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ISSUE;
            pc_r    <= RESET_PC;
            addr_r  <= 32'h0000_0000;
            inst_r  <= NOP_INST;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                ISSUE: begin
                    if (bus.PCSrcE) begin
                        pc_r <= align_target(bus.PCTargetE);
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.PCSrcE) begin
                        pc_r    <= align_target(bus.PCTargetE);
                        state_r <= bus.imem_rvalid ? ISSUE : DROP;
                    end else if (bus.imem_rvalid) begin
                        addr_r  <= pc_r;
                        inst_r  <= bus.imem_rdata;
                        valid_r <= 1'b1;
                        pc_r    <= pc_r + 32'd4;
                        state_r <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.PCSrcE) begin
                        pc_r    <= align_target(bus.PCTargetE);
                        valid_r <= 1'b0;
                        addr_r  <= 32'h0000_0000;
                        inst_r  <= NOP_INST;
                        state_r <= ISSUE;
                    end else if (!bus.StallF) begin
                        // Consumed by IF/ID; the next request left this cycle.
                        valid_r <= 1'b0;
                        addr_r  <= 32'h0000_0000;
                        inst_r  <= NOP_INST;
                        state_r <= WAIT;
                    end
                end
                DROP: begin
                    if (bus.PCSrcE) begin
                        pc_r <= align_target(bus.PCTargetE);
                    end
                    if (bus.imem_rvalid) begin
                        state_r <= ISSUE;
                    end
                end
                default: begin
                    state_r <= ISSUE;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_s;
    assign bus.imem_addr = pc_r;
    assign bus.Addr      = addr_r;
    assign bus.Inst      = inst_r;
    assign bus.InstValid = valid_r;
    assign bus.PCF       = pc_r;

endmodule
